// File: rtl/oam_dma_ctrl.sv
`timescale 1ns/1ps
// oam_dma_ctrl: sprite DMA engine behind the NES $4014 register.
// A CPU write of page P to $4014 halts the CPU. The engine then copies
// $PP00..$PP(XFER_LEN-1) from one port of the system RAM into PPU OAM,
// starting at the OAMADDR value latched on the trigger cycle.
// XFER_LEN must be a power of two and no larger than 256.
//
// Ports:
//   clk        system clock, one CPU cycle per edge
//   reset      asynchronous active-high reset
//   cpu_addr   CPU bus address
//   cpu_wdata  CPU write data (page number on a trigger)
//   cpu_we     CPU write strobe
//   oam_base   current OAMADDR ($2003)
//   mem_addr   RAM port address, valid while mem_sel=1
//   mem_sel    RAM port address is owned by this block
//   mem_rdata  RAM port read data, one cycle after the address
//   oam_addr   OAM write address
//   oam_wdata  OAM write data
//   oam_we     OAM write strobe, one cycle per byte
//   cpu_halt   CPU stall (RDY low)
//   busy       DMA in progress
//   done       one-cycle pulse after the last OAM write
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int unsigned XFER_LEN     = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic [7:0]  oam_base,
   output logic [15:0] mem_addr,
   output logic        mem_sel,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_we,
   output logic        cpu_halt,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t      r_state;
   logic        r_parity;
   logic [7:0]  r_page;
   logic [7:0]  r_base;
   logic [7:0]  r_idx;
   logic [15:0] r_mem_addr;
   logic        r_mem_sel;
   logic [7:0]  r_oam_addr;
   logic        r_oam_we;
   logic        r_cpu_halt;
   logic        r_busy;
   logic        r_done;

   logic        w_trigger;

   assign w_trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

   // Controller: outputs are registered from the state being entered, so
   // they line up with that state during its cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_parity   <= 1'b0;
         r_page     <= 8'h00;
         r_base     <= 8'h00;
         r_idx      <= 8'h00;
         r_mem_addr <= 16'h0000;
         r_mem_sel  <= 1'b0;
         r_oam_addr <= 8'h00;
         r_oam_we   <= 1'b0;
         r_cpu_halt <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         // Free-running get/put phase; 0 marks an even (get) cycle.
         r_parity   <= ~r_parity;
         r_mem_addr <= 16'h0000;
         r_mem_sel  <= 1'b0;
         r_oam_addr <= 8'h00;
         r_oam_we   <= 1'b0;
         r_done     <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_cpu_halt <= 1'b0;
               r_busy     <= 1'b0;
               if (w_trigger) begin
                  r_page     <= cpu_wdata;
                  r_base     <= oam_base;
                  r_idx      <= 8'h00;
                  r_state    <= S_HALT;
                  r_cpu_halt <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end

            // Odd HALT cycle means the next one is even: read right away.
            S_HALT: begin
               if (r_parity) begin
                  r_state    <= S_READ;
                  r_mem_sel  <= 1'b1;
                  r_mem_addr <= {r_page, r_idx};
               end else begin
                  r_state <= S_ALIGN;
               end
            end

            S_ALIGN: begin
               r_state    <= S_READ;
               r_mem_sel  <= 1'b1;
               r_mem_addr <= {r_page, r_idx};
            end

            S_READ: begin
               r_state    <= S_WRITE;
               r_oam_we   <= 1'b1;
               r_oam_addr <= r_base + r_idx;
            end

            S_WRITE: begin
               if (r_idx == IDX_LAST) begin
                  r_state    <= S_IDLE;
                  r_done     <= 1'b1;
                  r_cpu_halt <= 1'b0;
                  r_busy     <= 1'b0;
               end else begin
                  r_idx      <= r_idx + 8'd1;
                  r_state    <= S_READ;
                  r_mem_sel  <= 1'b1;
                  r_mem_addr <= {r_page, r_idx + 8'd1};
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_cpu_halt <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr = r_mem_addr;
   assign mem_sel  = r_mem_sel;
   assign oam_addr = r_oam_addr;
   assign oam_we   = r_oam_we;
   assign cpu_halt = r_cpu_halt;
   assign busy     = r_busy;
   assign done     = r_done;

   // The RAM port already registers its data, so the byte is forwarded
   // straight through in the WRITE cycle; gated to 0 outside of it.
   assign oam_wdata = r_oam_we ? mem_rdata : 8'h00;

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA engine for the NES core; implements the $4014 register.
- A CPU write of page P to $4014 halts the CPU and copies bytes $PP00-$PPFF from the 64 KiB dual-port system RAM into PPU OAM, starting at the current OAMADDR.
- The block sits directly upstream of one RAM port: it drives that port's address during DMA and consumes the port's read data one clock later.
- One clk edge equals one CPU cycle.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA
- XFER_LEN, 256, bytes per transfer; must be a power of two, at most 256

Ports:
- clk  in  1  system clock, one CPU cycle per edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU bus address
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- oam_base  in  8  current OAMADDR ($2003) value
- mem_addr  out  16  address for the RAM port; valid while mem_sel=1
- mem_sel  out  1  1 = the bus mux gives the RAM port address to this block
- mem_rdata  in  8  RAM port data_out; registered, valid the cycle after its address was presented
- oam_addr  out  8  OAM write address
- oam_wdata  out  8  OAM write data
- oam_we  out  1  OAM write strobe, one cycle per byte
- cpu_halt  out  1  CPU stall (RDY low)
- busy  out  1  DMA in progress
- done  out  1  one-cycle pulse after the last OAM write

Behaviour:
- Reset (async): state=IDLE, parity=0, page=0, idx=0.
  - All outputs are 0 while reset is asserted and on the first cycle after release.
- parity flop:
  - Toggles on every clk edge from reset, independent of DMA.
  - parity=0 marks a "get" (even) cycle.
- IDLE:
  - Trigger: cpu_we=1 and cpu_addr=DMA_REG_ADDR.
  - On trigger, latch page<=cpu_wdata, base<=oam_base, idx<=0, then go to HALT.
- HALT: one dummy cycle.
  - If parity=1, go to READ (READ then lands on an even cycle).
  - Else go to ALIGN.
- ALIGN: one dummy cycle, then go to READ.
- READ:
  - mem_sel=1, mem_addr={page, idx}.
  - Go to WRITE.
- WRITE:
  - oam_we=1, oam_addr=base+idx (mod 256, wraps), oam_wdata=mem_rdata.
  - If idx=XFER_LEN-1: go to IDLE and pulse done on the next cycle.
  - Else idx<=idx+1 and go to READ.
- Outputs by state:
  - cpu_halt=1 and busy=1 in HALT, ALIGN, READ and WRITE.
  - Both are 0 in IDLE, including the trigger cycle itself; the CPU write completes.
  - oam_we=0 in all states except WRITE.
  - mem_sel=0 in all states except READ.
- Latency: trigger edge to the first cycle with cpu_halt=0 is 514 cycles (HALT→READ) or 515 (HALT→ALIGN→READ), done pulse included.
- Boundaries:
  - A trigger while busy is ignored; page and base are unchanged.
  - oam_base changes during DMA are ignored; base stays latched.
  - With base=8'hF0, writes go to F0..FF, then 00..EF.
  - Page $FF reads $FF00-$FFFF; no overflow into other pages.
  - Reset mid-transfer aborts immediately. Bytes already written stay in OAM; no done pulse.
  - A trigger in the same cycle as done is accepted and starts a new DMA.

Test Plan:
- Reset, then write 8'h02 to $4014 on a cycle where parity=0. Expect HALT with parity=1 → READ. RAM $0200+i=i^8'h5A. Expect 256 oam_we pulses, oam_addr 00..FF, oam_wdata=i^8'h5A, cpu_halt high for exactly 513 cycles, done 1 cycle later.
- Same trigger one cycle later (HALT parity=0). Expect one ALIGN cycle, cpu_halt high for 514 cycles, and every READ with parity=0.
- oam_base=8'hF0, page 8'h03. Expect first write oam_addr=F0 with data=mem[$0300], and the write of mem[$0310] at oam_addr=00.
- During DMA, write 8'h07 to $4014 and change oam_base. Expect the transfer to continue from the original page and base, with no restart.
- Assert reset after the 100th oam_we. Expect all outputs 0 asynchronously, no done pulse, then IDLE; a fresh trigger completes normally.
- Write to $4013 and $4015, and read $4014 with cpu_we=0. Expect no busy and no cpu_halt.
